// File: rtl/apb_completer.sv
// APB completer: 16 x 8-bit register file behind an IDLE/WAIT/READY FSM. pready rises WAIT_CYCLES+2 cycles after setup.
// The completer stalls every access for WAIT_CYCLES extra cycles; dropping psel in WAIT aborts the transfer without side effects.
module apb_completer #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] addr_q;
    logic       write_q;
    logic [7:0] wdata_q;
    logic [7:0] regs [16];

    logic       setup;
    logic       addr_ok;

    assign setup   = psel && !penable;
    // Only the low sixteen byte addresses map onto storage.
    assign addr_ok = (addr_q[7:4] == 4'h0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            addr_q  <= 8'h00;
            write_q <= 1'b0;
            wdata_q <= 8'h00;
            prdata  <= 8'h00;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        cnt     <= WAIT_LOAD;
                        state   <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (!penable) begin
                        // A fresh setup phase restarts the transfer from scratch.
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        cnt     <= WAIT_LOAD;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state  <= ST_READY;
                        pready <= 1'b1;
                        if (!addr_ok) begin
                            pslverr <= 1'b1;
                            if (!write_q) begin
                                prdata <= 8'h00;
                            end
                        end else if (write_q) begin
                            regs[addr_q[3:0]] <= wdata_q;
                        end else begin
                            prdata <= regs[addr_q[3:0]];
                        end
                    end
                end

                ST_READY: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (setup) begin
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        cnt     <= WAIT_LOAD;
                        state   <= ST_WAIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_completer.md
APB_COMPLETER -- requirements
Module: apb_completer

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, SHALL set the number of extra access-phase wait cycles; legal range 0..15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 psel  input  1  completer selected.
REQ-005 penable  input  1  access-phase indicator.
REQ-006 pwrite  input  1  1 = write, 0 = read.
REQ-007 paddr  input  8  byte address.
REQ-008 pwdata  input  8  write data.
REQ-009 prdata  output  8  read data; registered.
REQ-010 pready  output  1  transfer complete; registered.
REQ-011 pslverr  output  1  transfer error; registered.

Function
REQ-012 Storage SHALL be 16 x 8-bit registers; paddr 0x00..0x0F is valid; paddr 0x10..0xFF is invalid.
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, READY.
REQ-014 In IDLE, on an edge with psel=1 and penable=0, the block SHALL latch paddr, pwrite and pwdata, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-015 In IDLE, any other input combination SHALL keep the block in IDLE.
REQ-016 In WAIT, on an edge with psel=1 and penable=1:
  - counter nonzero: decrement the counter and stay in WAIT.
  - counter zero: complete the transfer and go to READY.
REQ-017 In WAIT, psel=0 SHALL abort the transfer: go to IDLE, no register update, no pready pulse.
REQ-018 In WAIT, psel=1 with penable=0 SHALL be treated as a new setup phase: re-latch all inputs and reload the counter.
REQ-019 Completion of a valid write SHALL update the latched register with the latched pwdata on the edge entering READY.
REQ-020 Completion of a valid read SHALL load prdata with the latched register's contents on the edge entering READY.
REQ-021 Completion with an invalid address SHALL set pslverr=1 and leave all registers unchanged; for a read, prdata SHALL be 0x00.
REQ-022 pready SHALL be 1 only in READY, for exactly one cycle per completed transfer.
REQ-023 pslverr SHALL be 0 whenever pready=0.
REQ-024 Timing: with setup in cycle 0, pready SHALL be high in cycle WAIT_CYCLES+2 (WAIT_CYCLES=0: cycle 2; default: cycle 3).
REQ-025 In READY, on the next edge:
  - psel=1 and penable=0: latch a new transfer and go to WAIT (back-to-back, no IDLE cycle).
  - otherwise: go to IDLE.
REQ-026 Changes on paddr, pwrite or pwdata during WAIT SHALL be ignored; the latched values are used.
REQ-027 prdata SHALL hold its last read value until the next read completes; writes SHALL not alter prdata.
REQ-028 Write-then-read of the same address in consecutive transfers SHALL return the newly written value.

Reset
REQ-029 rstn=0 SHALL immediately, without waiting for a clock edge:
  - set the FSM to IDLE and the counter to 0;
  - clear all 16 registers to 0x00;
  - drive prdata=0x00, pready=0, pslverr=0.
REQ-030 Reset asserted mid-transfer SHALL discard the transfer; no register update survives unless it was already completed.
REQ-031 After rstn deasserts, the first setup phase SHALL be accepted on the first rising edge.

Verification
REQ-032 Bench SHALL cover, with WAIT_CYCLES=1:
  - Reset, then read addr 0x05 -> prdata=0x00, pslverr=0, pready high in cycle 3 only.
  - Write 0xA5 to 0x03, then read 0x03 back-to-back -> prdata=0xA5; pready pulses one cycle per transfer with no IDLE cycle between.
  - Write 0x77 to 0x20 -> pslverr=1 with pready; a following read of 0x00 returns its prior value; no register changed.
  - Read 0x40 -> prdata=0x00, pslverr=1.
  - Write 0x3C to 0x0A with psel dropped during WAIT -> no pready pulse; read 0x0A returns 0x00.
  - Write 0x11 to 0x01, then rstn pulsed low mid-transfer -> outputs zero immediately; read 0x01 returns 0x00.
REQ-033 The WAIT_CYCLES=0 and WAIT_CYCLES=4 builds SHALL each show pready in cycle 2 and cycle 6 respectively.
